// File: rtl/priority_encoder_8_3_seq.sv
// Sequential 8:3 priority encoder: collects request pulses into a pending register
// and presents the highest-numbered pending line as an index over valid/ready.
module priority_encoder_8_3_seq #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_in,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  pending,
  output logic [IW:0]   pend_cnt,
  output logic          dropped
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t        state;
  logic          fire;
  logic [N-1:0]  acc_mask;
  logic [N-1:0]  p;
  logic [IW-1:0] p_idx;
  logic [IW:0]   p_cnt;

  // The state register is the valid flag, so out_valid is still a flop output.
  assign out_valid = (state == PRESENT);
  assign fire      = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_mask = '0;
    if (fire) acc_mask[out_idx] = 1'b1;
    p = (pending & ~acc_mask) | req_in;
  end

  // Ascending scan: the last set bit seen is the highest, which is the winner.
  always_comb begin
    p_idx = '0;
    p_cnt = '0;
    for (int k = 0; k < N; k++) begin
      if (p[k]) begin
        p_idx = IW'(k);
        p_cnt = p_cnt + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_idx  <= '0;
      pending  <= '0;
      pend_cnt <= '0;
      dropped  <= 1'b0;
    end else if (clr) begin
      // out_idx is left alone: it is don't-care while out_valid is low.
      state    <= IDLE;
      pending  <= '0;
      pend_cnt <= '0;
      dropped  <= 1'b0;
    end else begin
      pending  <= p;
      pend_cnt <= p_cnt;
      dropped  <= |(req_in & pending & ~acc_mask);
      case (state)
        IDLE: begin
          if (p != '0) begin
            out_idx <= p_idx;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          // Without a handshake the presented index is held; no preemption.
          if (fire) begin
            if (p != '0) out_idx <= p_idx;
            else         state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
